// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral exposing a bank of NUM_REGS registers.
// Frames carry {rw, address, data}, MSB first, with sclk/cs_n/copi resynchronised to clk.
module spi_reg_bank #(
    parameter int                NUM_REGS    = 5,
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 7,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sclk,
    input  logic                         cs_n,
    input  logic                         copi,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic                         frame_err
);
    // state   | meaning
    // IDLE    | waiting for a synchronised cs_n falling edge
    // CMD     | shifting in the rw bit and the address
    // DATA    | shifting in write data / shifting out read data
    // WAIT_CS | frame complete, sclk ignored until cs_n rises
    localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_WAIT_CS} state_t;

    state_t                    r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0]    r_sclk_sync, r_cs_sync, r_copi_sync;
    logic                      r_sclk_prev, r_cs_prev;
    logic [FRAME_LEN-1:0]      r_shift;
    logic [CNT_W-1:0]          r_bit_cnt;
    logic [DATA_W-1:0]         r_tx;
    logic                      r_is_read, r_cipo, r_cipo_oe, r_frame_err;
    logic [NUM_REGS-1:0]       r_wr_strobe;
    logic [DATA_W-1:0]         r_regs [NUM_REGS];

    logic                      w_sclk_s, w_cs_s, w_copi_s;
    logic                      w_sclk_rise, w_sclk_fall, w_cs_fall;
    logic                      w_start, w_shift_en, w_cmd_done, w_frame_done, w_abort, w_tx_shift;
    logic [FRAME_LEN-1:0]      w_shift_nxt;
    logic [ADDR_W-1:0]         w_cmd_addr, w_fr_addr;
    logic [DATA_W-1:0]         w_fr_data, w_rd_data;
    logic                      w_fr_write, w_fr_addr_ok;

    // cs_n chain resets low so a frame already in progress at reset release
    // never produces a falling edge; the controller must start a fresh frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_copi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
            r_sclk_prev <= w_sclk_s;
            r_cs_prev   <= w_cs_s;
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_copi_s    = r_copi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_prev;
    assign w_cs_fall   = ~w_cs_s & r_cs_prev;

    assign w_shift_nxt = {r_shift[FRAME_LEN-2:0], w_copi_s};
    assign w_cmd_addr  = w_shift_nxt[ADDR_W-1:0];
    assign w_fr_write  = w_shift_nxt[FRAME_LEN-1];
    assign w_fr_addr   = w_shift_nxt[DATA_W +: ADDR_W];
    assign w_fr_data   = w_shift_nxt[DATA_W-1:0];

    always_comb begin
        w_rd_data    = '0;
        w_fr_addr_ok = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (w_cmd_addr == ADDR_W'(k)) w_rd_data = r_regs[k];
            if (w_fr_addr == ADDR_W'(k))  w_fr_addr_ok = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_start      = 1'b0;
        w_shift_en   = 1'b0;
        w_cmd_done   = 1'b0;
        w_frame_done = 1'b0;
        w_abort      = 1'b0;
        w_tx_shift   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cs_fall) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_CMD;
                end
            end
            S_CMD: begin
                if (w_cs_s) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_sclk_rise) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == CNT_W'(ADDR_W)) begin
                        w_cmd_done  = 1'b1;
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_cs_s) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_sclk_rise) begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == CNT_W'(FRAME_LEN - 1)) begin
                        w_frame_done = 1'b1;
                        w_state_nxt  = S_WAIT_CS;
                    end
                end else if (w_sclk_fall && r_is_read) begin
                    w_tx_shift = 1'b1;
                end
            end
            S_WAIT_CS: begin
                if (w_cs_s) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_tx        <= '0;
            r_is_read   <= 1'b0;
            r_cipo      <= 1'b0;
            r_cipo_oe   <= 1'b0;
            r_wr_strobe <= '0;
            r_frame_err <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= RESET_VAL;
        end else begin
            r_wr_strobe <= '0;
            r_frame_err <= w_abort;
            if (w_start) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
                r_tx      <= '0;
            end
            if (w_shift_en) begin
                r_shift   <= w_shift_nxt;
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_cmd_done) begin
                r_is_read <= ~w_fr_write ? 1'b0 : 1'b0;
                r_is_read <= ~w_shift_nxt[ADDR_W];
                r_tx      <= w_rd_data;
            end
            if (w_tx_shift) begin
                r_cipo    <= r_tx[DATA_W-1];
                r_tx      <= r_tx << 1;
                r_cipo_oe <= 1'b1;
            end
            if (w_state_nxt != S_DATA) begin
                r_cipo    <= 1'b0;
                r_cipo_oe <= 1'b0;
            end
            if (w_frame_done) begin
                if (!w_fr_addr_ok) begin
                    r_frame_err <= 1'b1;
                end else if (w_fr_write) begin
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (w_fr_addr == ADDR_W'(k)) begin
                            r_regs[k]      <= w_fr_data;
                            r_wr_strobe[k] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_flat
            assign regs[g*DATA_W +: DATA_W] = r_regs[g];
        end
    endgenerate

    assign cipo      = r_cipo & r_cipo_oe;
    assign cipo_oe   = r_cipo_oe;
    assign wr_strobe = r_wr_strobe;
    assign frame_err = r_frame_err;

endmodule
